// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider (DIV/DIVU) for the HI/LO unit.
// Produces one quotient bit per cycle on operand magnitudes, then fixes signs.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] orig_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             dbz_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_by_zero_reg;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic             take;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        dvd_neg = div_signed & dividend[WIDTH-1];
        dvs_neg = div_signed & divisor[WIDTH-1];
        dvd_abs = dvd_neg ? -dividend : dividend;
        dvs_abs = dvs_neg ? -divisor : divisor;
        // The shifted partial remainder can exceed WIDTH bits, so compare at
        // WIDTH+1; the difference itself always fits in WIDTH bits.
        shifted = {rem_reg, quo_reg[WIDTH-1]};
        take    = shifted >= {1'b0, dvs_reg};
        trial   = shifted[WIDTH-1:0] - dvs_reg;
        q_fix   = q_neg_reg ? -quo_reg : quo_reg;
        r_fix   = r_neg_reg ? -rem_reg : rem_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            count_reg       <= '0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            dvs_reg         <= '0;
            orig_reg        <= '0;
            q_neg_reg       <= 1'b0;
            r_neg_reg       <= 1'b0;
            dbz_reg         <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (div_start && !cancel) begin
                        rem_reg   <= '0;
                        quo_reg   <= dvd_abs;
                        dvs_reg   <= dvs_abs;
                        orig_reg  <= dividend;
                        q_neg_reg <= dvd_neg ^ dvs_neg;
                        r_neg_reg <= dvd_neg;
                        dbz_reg   <= (divisor == '0);
                        count_reg <= '0;
                        state_reg <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state_reg <= S_IDLE;
                    end else begin
                        rem_reg   <= take ? trial : shifted[WIDTH-1:0];
                        quo_reg   <= {quo_reg[WIDTH-2:0], take};
                        count_reg <= count_reg + CW'(1);
                        if (count_reg == CW'(WIDTH - 1)) begin
                            state_reg <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        state_reg <= S_IDLE;
                    end else begin
                        // Divide by zero reports all-ones and the untouched dividend.
                        quotient_reg    <= dbz_reg ? '1 : q_fix;
                        remainder_reg   <= dbz_reg ? orig_reg : r_fix;
                        div_by_zero_reg <= dbz_reg;
                        state_reg       <= S_DONE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vectors plus a cycle-level
// arithmetic reference model compared against the DUT on every cycle.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    div_iter #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference result {div_by_zero, quotient, remainder} from plain arithmetic.
    function automatic logic [64:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q = x / y;
        r = x % y;
        return {1'b0, q[31:0], r[31:0]};
    endfunction

    // Model: k counts cycles since an accepted start (0 = idle, 34 = done cycle).
    int          k = 0;
    logic [64:0] pend = '0;
    logic [31:0] mq = '0;
    logic [31:0] mr = '0;
    logic        mz = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            k  <= 0;
            mq <= '0;
            mr <= '0;
            mz <= 1'b0;
        end else if (k == 0) begin
            if (div_start && !cancel) begin
                k    <= 1;
                pend <= ref_div(div_signed, dividend, divisor);
            end
        end else if (k == 34) begin
            k <= 0;
        end else if (cancel) begin
            k <= 0;
        end else begin
            k <= k + 1;
            if (k == 33) {mz, mq, mr} <= pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", {31'd0, busy}, {31'd0, k != 0});
            chk("model_done", {31'd0, done}, {31'd0, k == 34});
            chk("model_quotient", quotient, mq);
            chk("model_remainder", remainder, mr);
            chk("model_dbz", {31'd0, div_by_zero}, {31'd0, mz});
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            output int c0);
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        div_start  = 1'b1;
        c0         = cyc;
        tick();
        div_start  = 1'b0;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic run_op(input string nm, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic ez, output int at);
        int c0;
        start_op(sgn, a, b, c0);
        wait_done(at);
        chk({nm, "_latency"}, at - c0, 32'd34);
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        chk({nm, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        $display("op %s: %h / %h signed=%0b -> q=%h r=%h dbz=%0b done after %0d",
                 nm, a, b, sgn, quotient, remainder, div_by_zero, at - c0);
        tick();
    endtask

    initial begin
        int at, at2, c0, c1;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, at);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, at);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, at);
        run_op("divu_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, at);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, at);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, at);
        run_op("div_zero_s", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, at);
        run_op("div_zero_u", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, at);

        // cancel together with start in IDLE: start is dropped
        div_start = 1'b1;
        cancel    = 1'b1;
        tick();
        div_start = 1'b0;
        cancel    = 1'b0;
        chk("cancel_start_idle_busy", {31'd0, busy}, 32'd0);
        $display("op cancel_with_start: busy=%0b", busy);

        // cancel in cycle 10, restart 9/3 in cycle 11, stray start in cycle 20
        start_op(1'b0, 32'd100, 32'd7, c0);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hold_q", quotient, 32'hFFFF_FFFF);
        chk("cancel_hold_r", remainder, 32'h1234_5678);
        start_op(1'b0, 32'd9, 32'd3, c1);
        chk("restart_cycle", c1 - c0, 32'd11);
        repeat (8) tick();
        dividend  = 32'd1000;
        divisor   = 32'd10;
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        wait_done(at);
        chk("cancel_restart_done_at", at - c0, 32'd45);
        chk("cancel_restart_q", quotient, 32'd3);
        chk("cancel_restart_r", remainder, 32'd0);
        $display("op cancel_restart_9_3: q=%h r=%h done at cycle %0d", quotient, remainder, at - c0);
        repeat (40) tick();

        // reset in cycle 15 of 100/7
        start_op(1'b0, 32'd100, 32'd7, c0);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        $display("op midop_reset: busy=%0b q=%h r=%h", busy, quotient, remainder);
        repeat (30) tick();

        run_op("b2b_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, at);
        run_op("b2b_51_5", 1'b0, 32'd51, 32'd5, 32'd10, 32'd1, 1'b0, at2);
        chk("b2b_gap", at2 - at, 32'd35);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit integer divider for the MIPS-lite execute stage. It implements DIV (signed) and DIVU (unsigned) using restoring radix-2 division on operand magnitudes, producing one quotient bit per cycle. It sits beside the Booth radix-4 multiplier in the HI/LO unit: quotient is written to LO and remainder to HI. The pipeline stalls on `busy`, and `cancel` flushes an in-flight operation on exception or branch squash.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width; bench covers 32 only.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `div_start`  in  1  request; sampled only in IDLE
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `div_start`
- `dividend`  in  WIDTH  sampled with `div_start`
- `divisor`  in  WIDTH  sampled with `div_start`
- `cancel`  in  1  abort the in-flight operation
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  single-cycle pulse; results are valid from this cycle onward
- `quotient`  out  WIDTH  registered; holds its value until the next `done`
- `remainder`  out  WIDTH  registered; holds its value until the next `done`
- `div_by_zero`  out  1  registered with the results; 1 if the divisor was 0

## Operation

- States: IDLE, CALC, FIX, DONE.
- IDLE, with `div_start=1`:
  - Latch `|dividend|` and `|divisor|`. Magnitudes apply only when `div_signed=1`; otherwise operands are taken raw.
  - Latch sign flags: quotient negative = sign(dividend) XOR sign(divisor); remainder negative = sign(dividend).
  - Clear the partial remainder (WIDTH+1 bits) and set count = 0. Go to CALC.
- CALC, each cycle:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quotient bit = 1; otherwise restore and set quotient bit = 0.
  - Increment count. After the WIDTH-th step, go to FIX.
- FIX: apply sign correction by two's-complement negation where the flags require it. Register `quotient`, `remainder` and `div_by_zero`. Go to DONE.
- DONE: `done=1` for this one cycle, then return to IDLE.
- Divide by zero: run the full latency, then force `quotient=32'hFFFFFFFF`, `remainder=dividend` (original value) and `div_by_zero=1`. This is independent of `div_signed`.
- Signed overflow (0x80000000 / 0xFFFFFFFF): no special case. The magnitude path yields `quotient=32'h80000000` and `remainder=0`.
- `div_start` is ignored while `busy=1`.
- `cancel` in CALC or FIX returns the block to IDLE at the next edge. `done` is not asserted and `quotient`/`remainder`/`div_by_zero` keep their previous values. `cancel` in DONE has no effect because results are already committed.
- `cancel` together with `div_start` in IDLE: the start is ignored.
- Priority: `rst` > `cancel` > `div_start`.

## Timing

- Reset values: state IDLE; `busy=0`, `done=0`, `quotient=0`, `remainder=0`, `div_by_zero=0`; internal count = 0.
- Latency, with `div_start` sampled high in cycle 0:
  - CALC occupies cycles 1..32.
  - FIX occupies cycle 33.
  - DONE occupies cycle 34: `done=1`, with results valid in that cycle.
  - Cycle 35 is IDLE again.
- `busy=1` in cycles 1..34. `busy` is 0 in cycle 0; the pipeline stalls the following instruction from cycle 1.
- Back-to-back: the earliest next accepted start is cycle 35, giving first `done` at 34 and second at 69.
- `rst` mid-operation: the next edge gives IDLE and all outputs return to their reset values, including discarding previously held results.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- DIVU, 100 / 7, `div_signed=0` -> `done` exactly 34 cycles after start; `quotient=14`, `remainder=2`, `div_by_zero=0`.
- DIV, 0xFFFFFFF9 (-7) / 2 -> `quotient=0xFFFFFFFD` (-3), `remainder=0xFFFFFFFF` (-1). Then 7 / 0xFFFFFFFE (-2) -> `quotient=0xFFFFFFFD`, `remainder=1`.
- DIV, 0x80000000 / 0xFFFFFFFF -> `quotient=0x80000000`, `remainder=0`. DIVU, 0xFFFFFFFF / 1 -> `quotient=0xFFFFFFFF`, `remainder=0`.
- Divide by zero, 0x12345678 / 0 (both signed and unsigned) -> `div_by_zero=1`, `quotient=0xFFFFFFFF`, `remainder=0x12345678`, `done` at cycle 34.
- Start 100/7 and pulse `cancel` in cycle 10 -> `busy=0` in cycle 11, no `done`, previous results unchanged. A new `div_start` in cycle 11 for 9/3 -> `done` at cycle 45 with `quotient=3`, `remainder=0`. A second `div_start` pulsed in cycle 20 is ignored.
- Assert `rst` in cycle 15 of a 100/7 operation -> outputs at reset values next cycle and no `done`. Then back-to-back 50/5 and 51/5 -> `done` at 34 and 69, giving `quotient=10`/`remainder=0` and `quotient=10`/`remainder=1`.
